demux1_n_stream: RTL and testbench
==================================

# demux1_n_stream

Parametrised, registered 1-to-N stream demultiplexer with valid/ready handshakes and packet-level routing. A beat arriving on the single input port goes to the output channel chosen by `S`. The channel choice is latched on the first beat of a packet and held until its `I_last` beat. Each output channel has a one-entry register, so throughput is one beat per clock at 1-cycle latency. It sits between a packet source and N downstream consumers and generalises the combinational 1:8 demux to any width and channel count.

## Interface
- `WIDTH`, 8, data bits per beat (>=1)
- `N_OUT`, 8, number of output channels (2..64)
- `SEL_W`, `$clog2(N_OUT)`, select width (derived, not overridden)
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `I_data`  in  WIDTH  input beat payload
- `I_valid`  in  1  input beat valid
- `I_last`  in  1  final beat of packet
- `I_ready`  out  1  block accepts the beat this cycle
- `S`  in  SEL_W  channel select, sampled only on the first beat of a packet
- `Y_data`  out  N_OUT*WIDTH  channel k payload at bits [k*WIDTH +: WIDTH]
- `Y_last`  out  N_OUT  per-channel last flag
- `Y_valid`  out  N_OUT  per-channel valid
- `Y_ready`  in  N_OUT  per-channel downstream ready
- `err_cnt`  out  8  saturating count of dropped packets (select >= N_OUT)
- `busy`  out  1  high while a packet is in progress (state != IDLE)

## Operation
- A beat transfers on the input when `I_valid & I_ready`. It transfers on channel k when `Y_valid[k] & Y_ready[k]`.
- FSM states:
  - IDLE: awaiting a first beat. On an accepted beat with `S < N_OUT`, latch `tgt = S` and write the beat to channel `tgt`. Go to PKT, or stay in IDLE if `I_last`. With `S >= N_OUT`: discard the beat and increment `err_cnt` (saturates at 255). Go to DROP, or stay in IDLE if `I_last`.
  - PKT: every accepted beat goes to channel `tgt`. `S` is ignored. Return to IDLE on the accepted `I_last` beat.
  - DROP: `I_ready = 1`. Beats are discarded. Return to IDLE on the accepted `I_last` beat.
- `I_ready`:
  - In IDLE/PKT: `I_ready = ~Y_valid[t] | Y_ready[t]`, where t = `S` in IDLE and `tgt` in PKT.
  - In IDLE with `S >= N_OUT`: `I_ready = 1`.
  - This is a combinational path from `Y_ready` to `I_ready`. It is the only comb path through the block.
- Channel register k: loads `{I_data, I_last}` and sets `Y_valid[k]` when written. Clears `Y_valid[k]` on a downstream transfer with no simultaneous write. Simultaneous write and drain: new beat loaded, `Y_valid[k]` stays 1.
- Non-target channels are never written. Their registered beats drain independently, so channels may hold beats from different packets at once.
- `Y_data` of a channel with `Y_valid=0` holds its last value. It is zero after reset.

## Timing
- Latency: beat accepted at edge n appears on `Y_valid`/`Y_data` after edge n, which is 1 cycle.
- Throughput: 1 beat/cycle while the target keeps `Y_ready=1`. There are no bubbles between packets, including back-to-back packets to different channels.
- Reset (async assert, sync release) sets:
  - state = IDLE, `tgt` = 0
  - `Y_valid` = 0, `Y_last` = 0, `Y_data` = 0
  - `err_cnt` = 0, `busy` = 0
- Reset mid-packet abandons the packet. The first beat after release is treated as a new packet's first beat.
- `I_valid` low mid-packet: state and `tgt` hold indefinitely.
- Single-beat packet (first beat has `I_last=1`): FSM stays in IDLE and the next cycle may target another channel.
- `err_cnt` at 255 stays 255 on further drops.

## Structure
- Package `demux_pkg` holds:
  - FSM state typedef (IDLE, PKT, DROP, 2-bit encoding)
  - `ERR_CNT_W = 8`
- Sub-module `demux_out_reg` is a one-entry register with valid/ready, parameter `WIDTH`. It is instantiated N_OUT times in a generate loop.
- The top level holds the FSM, the `tgt` register, `I_ready` muxing, write-enable decode and the error counter.

## Test plan
- Reset, then `S=3`, `I_data=8'hA5`, `I_last=1`, all `Y_ready=1` -> one cycle later `Y_valid=8'b0000_1000`, channel 3 data `A5`, `Y_last[3]=1`. Other channels stay invalid and the FSM stays in IDLE.
- 4-beat packet `11,22,33,44` with `S=5` on beat 0, `S` changed to 2 on beats 1-3 -> all four beats appear on channel 5 on consecutive cycles. `busy` is high for beats 1-3.
- Channel 6 `Y_ready=0` during a 3-beat packet to channel 6 -> first beat is registered, then `I_ready=0`. `Y_data` holds it. Raising `Y_ready` resumes 1 beat/cycle with no loss or duplication.
- `N_OUT=6` build, `S=7`, 3-beat packet -> `I_ready` is 1 throughout, no `Y_valid`, `err_cnt=1`. 300 such single-beat packets -> `err_cnt=255`.
- Assert `rst_n=0` asynchronously on beat 2 of a 4-beat packet -> outputs clear immediately. After release, a beat with `S=1`, `I_last=1` routes to channel 1.
- Back-to-back single-beat packets to channels 0, 7, 0 with all ready -> three consecutive cycles of `Y_valid` = `01`, `80`, `01` (hex).

Source files
------------

// File: rtl/demux1_n_stream_pkg.sv
// Shared types and constants for the 1-to-N packet stream demultiplexer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package demux_pkg;

    // Packet-level routing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,    // waiting for the first beat of a packet
        PKT  = 2'd1,    // forwarding the rest of a packet to the latched channel
        DROP = 2'd2     // swallowing the rest of a packet with an illegal select
    } state_t;

    localparam int ERR_CNT_W = 8;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/demux1_n_stream_if.sv
// Stream bundle between a packet source, the demux and its N consumers.
// Latency: n/a (wiring only).
// Backpressure: I_ready flows back to the source, Y_ready flows in from each consumer.
interface demux1_n_stream_if #(
    parameter int WIDTH = 8,
    parameter int N_OUT = 8
);
    localparam int SEL_W = $clog2(N_OUT);

    // Single input port
    logic [WIDTH-1:0]       I_data;
    logic                   I_valid;
    logic                   I_last;
    logic                   I_ready;
    logic [SEL_W-1:0]       S;

    // N output channels, channel k payload at [k*WIDTH +: WIDTH]
    logic [N_OUT*WIDTH-1:0] Y_data;
    logic [N_OUT-1:0]       Y_last;
    logic [N_OUT-1:0]       Y_valid;
    logic [N_OUT-1:0]       Y_ready;

    // Demux side: consumes the input stream, produces the channel streams.
    modport slave (
        input  I_data, I_valid, I_last, S, Y_ready,
        output I_ready, Y_data, Y_last, Y_valid
    );

    // Environment side: drives the input stream and the channel readies.
    modport master (
        output I_data, I_valid, I_last, S, Y_ready,
        input  I_ready, Y_data, Y_last, Y_valid
    );

endinterface

// File: rtl/demux1_n_stream_out_reg.sv
// One-entry output register for a single demux channel (payload + last flag).
// Latency: 1 cycle from write to valid.
// Backpressure: 'free' is high when the slot is empty or drains this cycle.
module demux_out_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_last,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             last,
    output logic             valid,
    output logic             free
);

    // A new beat may be written when nothing is held or the held beat leaves now.
    assign free = ~valid | ready;

    // Payload only changes on a write, so an idle channel keeps its last beat visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
            last <= 1'b0;
        end else if (wr_en) begin
            data <= wr_data;
            last <= wr_last;
        end
    end

    // Valid is set by a write (even one that coincides with a drain), cleared by a bare drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (wr_en) begin
            valid <= 1'b1;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux1_n_stream.sv
// Registered 1-to-N packet demux: channel picked on a packet's first beat, held until its last.
// Latency: 1 cycle input to channel output; 1 beat/clock sustained, no inter-packet bubbles.
// Backpressure: I_ready follows the target channel's slot (comb from Y_ready); drops always accept.
module demux1_n_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_OUT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    demux1_n_stream_if.slave     bus,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 busy
);

    localparam int SEL_W = $clog2(N_OUT);

    state_t             state;
    state_t             state_nxt;
    logic [SEL_W-1:0]   tgt;
    logic [SEL_W-1:0]   tgt_nxt;
    logic [SEL_W-1:0]   cur;
    logic               sel_ok;
    logic               accept;
    logic               do_write;
    logic               err_inc;
    logic               free_sel;
    logic [N_OUT-1:0]   free;
    logic [N_OUT-1:0]   wr_en;

    logic [N_OUT*WIDTH-1:0] y_data;
    logic [N_OUT-1:0]       y_last;
    logic [N_OUT-1:0]       y_valid;

    // A select can only be out of range when N_OUT is not a power of two.
    generate
        if ((1 << SEL_W) == N_OUT) begin : g_sel_full
            assign sel_ok = 1'b1;
        end else begin : g_sel_part
            assign sel_ok = (32'(bus.S) < 32'(N_OUT));
        end
    endgenerate

    // Channel currently addressed: the live select on a first beat, the latched one mid-packet.
    always_comb begin
        cur = (state == PKT) ? tgt : bus.S;
    end

    // Look up whether the addressed channel can take a beat this cycle.
    always_comb begin
        free_sel = 1'b0;
        for (int k = 0; k < N_OUT; k++) begin
            if (cur == SEL_W'(k)) begin
                free_sel = free[k];
            end
        end
    end

    // Input ready: follow the addressed channel, but never stall beats that will be thrown away.
    always_comb begin
        bus.I_ready = 1'b1;
        case (state)
            IDLE:    bus.I_ready = sel_ok ? free_sel : 1'b1;
            PKT:     bus.I_ready = free_sel;
            default: bus.I_ready = 1'b1;
        endcase
    end

    assign accept = bus.I_valid & bus.I_ready;

    // Next-state, target latch, write strobe and drop detection for the packet FSM.
    always_comb begin
        state_nxt = state;
        tgt_nxt   = tgt;
        do_write  = 1'b0;
        err_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (sel_ok) begin
                        tgt_nxt   = bus.S;
                        do_write  = 1'b1;
                        state_nxt = bus.I_last ? IDLE : PKT;
                    end else begin
                        err_inc   = 1'b1;
                        state_nxt = bus.I_last ? IDLE : DROP;
                    end
                end
            end
            PKT: begin
                if (accept) begin
                    do_write = 1'b1;
                    if (bus.I_last) begin
                        state_nxt = IDLE;
                    end
                end
            end
            DROP: begin
                if (accept && bus.I_last) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // One-hot write enable onto the addressed channel.
    always_comb begin
        wr_en = '0;
        for (int k = 0; k < N_OUT; k++) begin
            wr_en[k] = do_write && (cur == SEL_W'(k));
        end
    end

    // FSM state and latched target channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            tgt   <= '0;
        end else begin
            state <= state_nxt;
            tgt   <= tgt_nxt;
        end
    end

    // Count packets dropped for an illegal select, saturating rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_inc) begin
            err_cnt <= sat_inc(err_cnt);
        end
    end

    assign busy = (state != IDLE);

    // Per-channel output slots; non-target channels keep draining on their own.
    generate
        for (genvar k = 0; k < N_OUT; k++) begin : g_ch
            demux_out_reg #(
                .WIDTH (WIDTH)
            ) u_out_reg (
                .clk     (clk),
                .rst_n   (rst_n),
                .wr_en   (wr_en[k]),
                .wr_data (bus.I_data),
                .wr_last (bus.I_last),
                .ready   (bus.Y_ready[k]),
                .data    (y_data[k*WIDTH +: WIDTH]),
                .last    (y_last[k]),
                .valid   (y_valid[k]),
                .free    (free[k])
            );
        end
    endgenerate

    assign bus.Y_data  = y_data;
    assign bus.Y_last  = y_last;
    assign bus.Y_valid = y_valid;

endmodule

// File: tb/tb_demux1_n_stream.sv
// Scoreboard bench for demux1_n_stream: an 8-channel instance for routing and a 6-channel one for drops.
// Latency: expected beats are queued at acceptance and popped by a monitor on channel transfers.
// Backpressure: channel readies are driven directly to exercise stalls.
module tb_demux1_n_stream;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    demux1_n_stream_if #(.WIDTH(8), .N_OUT(8)) bus8 ();
    demux1_n_stream_if #(.WIDTH(8), .N_OUT(6)) bus6 ();

    logic [7:0] err8;
    logic [7:0] err6;
    logic       busy8;
    logic       busy6;

    demux1_n_stream #(.WIDTH(8), .N_OUT(8)) dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus8),
        .err_cnt (err8),
        .busy    (busy8)
    );

    demux1_n_stream #(.WIDTH(8), .N_OUT(6)) dut6 (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus6),
        .err_cnt (err6),
        .busy    (busy6)
    );

    typedef struct packed {
        logic [2:0] ch;
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    c0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // Monitor: every channel transfer on the 8-channel DUT must match the next expected beat.
    beat_t got_beat;
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 8; k++) begin
                if (bus8.Y_valid[k] && bus8.Y_ready[k]) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL sb_unexpected: channel %0d data %0h with empty scoreboard",
                                 k, bus8.Y_data[k*8 +: 8]);
                    end else begin
                        got_beat = exp_q.pop_front();
                        check("sb_ch",   64'(k), 64'(got_beat.ch));
                        check("sb_data", 64'(bus8.Y_data[k*8 +: 8]), 64'(got_beat.data));
                        check("sb_last", 64'(bus8.Y_last[k]), 64'(got_beat.last));
                    end
                end
            end
        end
    end

    // Present a beat, wait until accepted, queue its expected channel output; returns 1 ns after the edge.
    task automatic send8(input logic [2:0] sel, input logic [2:0] ch, input logic [7:0] d, input logic last);
        beat_t b;
        bus8.S       = sel;
        bus8.I_data  = d;
        bus8.I_last  = last;
        bus8.I_valid = 1'b1;
        for (int w = 0; w < 100; w++) begin
            @(negedge clk);
            if (bus8.I_ready) begin
                b.ch   = ch;
                b.data = d;
                b.last = last;
                exp_q.push_back(b);
                @(posedge clk);
                #1;
                return;
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: beat %0h never accepted, I_ready %0b expected 1", d, bus8.I_ready);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, sim time %0t expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus8.I_valid = 1'b0; bus8.I_data = '0; bus8.I_last = 1'b0; bus8.S = '0; bus8.Y_ready = '1;
        bus6.I_valid = 1'b0; bus6.I_data = '0; bus6.I_last = 1'b0; bus6.S = '0; bus6.Y_ready = '1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_yvalid", 64'(bus8.Y_valid), 64'h0);
        check("rst_ydata",  64'(bus8.Y_data),  64'h0);
        check("rst_ylast",  64'(bus8.Y_last),  64'h0);
        check("rst_err",    64'(err8),         64'h0);
        check("rst_busy",   64'(busy8),        64'h0);
        check("rst_iready", 64'(bus8.I_ready), 64'h1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-beat packet to channel 3
        send8(3'd3, 3'd3, 8'hA5, 1'b1);
        bus8.I_valid = 1'b0;
        check("t1_yvalid", 64'(bus8.Y_valid),        64'h08);
        check("t1_data",   64'(bus8.Y_data[31:24]),  64'hA5);
        check("t1_ylast",  64'(bus8.Y_last),         64'h08);
        check("t1_busy",   64'(busy8),               64'h0);
        @(posedge clk);
        #1;
        check("t1_drained", 64'(bus8.Y_valid),       64'h0);
        check("t1_hold",    64'(bus8.Y_data[31:24]), 64'hA5);

        // 4-beat packet to channel 5; select changes after the first beat are ignored
        c0 = cyc;
        send8(3'd5, 3'd5, 8'h11, 1'b0);
        check("t2_busy1", 64'(busy8), 64'h1);
        send8(3'd2, 3'd5, 8'h22, 1'b0);
        check("t2_busy2", 64'(busy8), 64'h1);
        send8(3'd2, 3'd5, 8'h33, 1'b0);
        check("t2_busy3", 64'(busy8), 64'h1);
        send8(3'd2, 3'd5, 8'h44, 1'b1);
        bus8.I_valid = 1'b0;
        check("t2_busy_end", 64'(busy8),        64'h0);
        check("t2_yvalid",   64'(bus8.Y_valid), 64'h20);
        check("t2_cycles",   64'(cyc - c0),     64'd4);

        // Stall channel 6 after the first beat, then release
        bus8.Y_ready[6] = 1'b0;
        send8(3'd6, 3'd6, 8'h61, 1'b0);
        bus8.S       = 3'd0;
        bus8.I_data  = 8'h62;
        bus8.I_last  = 1'b0;
        bus8.I_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_iready_stall", 64'(bus8.I_ready),       64'h0);
            check("t3_yvalid_stall", 64'(bus8.Y_valid),       64'h40);
            check("t3_data_hold",    64'(bus8.Y_data[55:48]), 64'h61);
        end
        @(posedge clk);
        #1;
        bus8.Y_ready[6] = 1'b1;
        c0 = cyc;
        send8(3'd0, 3'd6, 8'h62, 1'b0);
        send8(3'd0, 3'd6, 8'h63, 1'b1);
        bus8.I_valid = 1'b0;
        check("t3_resume_cycles", 64'(cyc - c0), 64'd2);
        repeat (2) @(posedge clk);
        #1;

        // Back-to-back single-beat packets to channels 0, 7, 0
        send8(3'd0, 3'd0, 8'hC0, 1'b1);
        check("t6_yvalid0", 64'(bus8.Y_valid), 64'h01);
        send8(3'd7, 3'd7, 8'hC7, 1'b1);
        check("t6_yvalid7", 64'(bus8.Y_valid), 64'h80);
        send8(3'd0, 3'd0, 8'hC1, 1'b1);
        check("t6_yvalid0b", 64'(bus8.Y_valid), 64'h01);
        bus8.I_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Asynchronous reset on beat 2 of a 4-beat packet
        send8(3'd4, 3'd4, 8'hB0, 1'b0);
        send8(3'd4, 3'd4, 8'hB1, 1'b0);
        bus8.I_data  = 8'hB2;
        bus8.I_valid = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_yvalid", 64'(bus8.Y_valid), 64'h0);
        check("t5_ydata",  64'(bus8.Y_data),  64'h0);
        check("t5_ylast",  64'(bus8.Y_last),  64'h0);
        check("t5_busy",   64'(busy8),        64'h0);
        exp_q.delete();
        bus8.I_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send8(3'd1, 3'd1, 8'h5A, 1'b1);
        bus8.I_valid = 1'b0;
        check("t5_after_yvalid", 64'(bus8.Y_valid), 64'h02);
        check("t5_after_busy",   64'(busy8),        64'h0);
        repeat (2) @(posedge clk);
        #1;
        check("sb_empty_main", 64'(exp_q.size()), 64'd0);

        // 6-channel instance: 3-beat packet with out-of-range select is dropped
        bus6.S       = 3'd7;
        bus6.I_data  = 8'hEE;
        bus6.I_valid = 1'b1;
        for (int b = 0; b < 3; b++) begin
            bus6.I_last = (b == 2);
            @(negedge clk);
            check("drop_iready", 64'(bus6.I_ready), 64'h1);
            check("drop_yvalid", 64'(bus6.Y_valid), 64'h0);
            if (b > 0) check("drop_busy", 64'(busy6), 64'h1);
            @(posedge clk);
            #1;
        end
        check("drop_err1", 64'(err6),  64'd1);
        check("drop_idle", 64'(busy6), 64'h0);

        // 300 more dropped single-beat packets: counter saturates at 255
        bus6.I_last = 1'b1;
        for (int i = 0; i < 300; i++) begin
            bus6.S = (i % 2 == 1) ? 3'd6 : 3'd7;
            @(negedge clk);
            check("sat_iready", 64'(bus6.I_ready), 64'h1);
            @(posedge clk);
            #1;
            if (i == 252) check("sat_err254", 64'(err6), 64'd254);
            if (i == 253) check("sat_err255", 64'(err6), 64'd255);
        end
        bus6.I_valid = 1'b0;
        check("sat_err_final", 64'(err6),         64'd255);
        check("sat_yvalid",    64'(bus6.Y_valid), 64'h0);

        // Legal select on the 6-channel instance still routes, counter unchanged
        bus6.S       = 3'd5;
        bus6.I_data  = 8'h55;
        bus6.I_last  = 1'b1;
        bus6.I_valid = 1'b1;
        @(posedge clk);
        #1;
        bus6.I_valid = 1'b0;
        check("n6_yvalid", 64'(bus6.Y_valid),        64'h20);
        check("n6_data",   64'(bus6.Y_data[47:40]),  64'h55);
        check("n6_err",    64'(err6),                64'd255);

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
